// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neural-node sequencing logic.
package nn_pkg;

    localparam int MAX_TERMS = 64;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_SETTLE = 3'd3,
        S_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/term_counter.sv
// Term index counter with a loadable terminal value; at_last flags the final term.
module term_counter
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] last_idx,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_last
);

    logic [CNT_W-1:0] limit;

    // The limit is latched once per evaluation so later num_terms changes cannot disturb it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
            limit <= '0;
        end else begin
            if (load) begin
                limit <= last_idx;
            end
            if (clear) begin
                count <= '0;
            end else if (inc) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign at_last = (count == limit);

endmodule

// File: rtl/node_sequencer.sv
// Sequences one node evaluation: clear, accumulate N terms, settle, then hold the result.
module node_sequencer
    import nn_pkg::*;
#(
    parameter int MAX_TERMS = nn_pkg::MAX_TERMS,
    parameter int DATA_W    = nn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              go,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic              abort,
    input  logic [DATA_W-1:0] node_out,
    input  logic              result_ready,
    output logic              start,
    output logic              reset_acc,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] eff_last;
    logic             at_last;
    logic             cnt_clear;
    logic             cnt_load;
    logic             cnt_inc;

    // Out-of-range requests (0 or above the maximum) fall back to the full term count.
    always_comb begin
        eff_last = num_terms - CNT_W'(1);
        if (num_terms == '0 || num_terms > MAX_N) begin
            eff_last = MAX_N - CNT_W'(1);
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:   if (go) next = S_CLEAR;
            S_CLEAR:  next = abort ? S_IDLE : S_ACCUM;
            S_ACCUM: begin
                if (abort)        next = S_IDLE;
                else if (at_last) next = S_SETTLE;
            end
            S_SETTLE: next = abort ? S_IDLE : S_RESULT;
            S_RESULT: begin
                if (abort)             next = S_IDLE;
                else if (result_ready) next = go ? S_CLEAR : S_IDLE;
            end
            default:  next = S_IDLE;
        endcase
    end

    assign cnt_load  = (next == S_CLEAR);
    assign cnt_clear = (next == S_IDLE) || (next == S_CLEAR);
    assign cnt_inc   = (state == S_ACCUM) && (next == S_ACCUM);

    term_counter u_term_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .last_idx (eff_last),
        .inc      (cnt_inc),
        .count    (cnt_val),
        .at_last  (at_last)
    );

    // Control outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= S_IDLE;
            start        <= 1'b1;
            reset_acc    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= next;
            start        <= (next != S_ACCUM);
            reset_acc    <= (next == S_CLEAR);
            busy         <= (next != S_IDLE);
            result_valid <= (next == S_RESULT);
            if (state == S_SETTLE && !abort) begin
                result <= node_out;
            end
        end
    end

endmodule

// File: tb/tb_node_sequencer.sv
// Scoreboard bench: a behavioural node consumes the sequencer controls; results are checked against a direct sum.
module tb_node_sequencer;

    localparam int N_MAX = 64;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          go = 1'b0;
    logic [6:0]    num_terms = '0;
    logic          abort = 1'b0;
    logic [DW-1:0] node_out;
    logic          result_ready = 1'b0;
    logic          start;
    logic          reset_acc;
    logic [6:0]    cnt_val;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;

    node_sequencer #(.MAX_TERMS(N_MAX), .DATA_W(DW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .go           (go),
        .num_terms    (num_terms),
        .abort        (abort),
        .node_out     (node_out),
        .result_ready (result_ready),
        .start        (start),
        .reset_acc    (reset_acc),
        .cnt_val      (cnt_val),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] value;
        int            edge_no;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          popped;
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    int            coef[128];
    int            data[128];
    int            acc;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] held;
    int            exp_idx = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [DW-1:0] act(input int x);
        if (x < 0) return '0;
        if (x > 32767) return 16'h7fff;
        return DW'(x);
    endfunction

    // Behavioural node: accumulates coef*data for the index it is handed while start is low.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)         acc <= 0;
        else if (reset_acc) acc <= 0;
        else if (!start)    acc <= acc + coef[cnt_val] * data[cnt_val];
    end

    assign node_out = act(acc);

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic int eff_n(input int nt);
        return (nt == 0 || nt > N_MAX) ? N_MAX : nt;
    endfunction

    function automatic logic [DW-1:0] ref_result(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += coef[i] * data[i];
        return act(s);
    endfunction

    task automatic randomize_terms();
        for (int i = 0; i < 128; i++) begin
            coef[i] = int'($urandom_range(255)) - 128;
            data[i] = int'($urandom_range(255)) - 128;
        end
    endtask

    // Called at a falling edge: go is sampled on the next rising edge.
    task automatic push_expected(input int nt);
        exp_t e;
        e.value   = ref_result(eff_n(nt));
        e.edge_no = edge_cnt + 1 + eff_n(nt) + 2;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input int nt);
        num_terms = 7'(nt);
        go = 1'b1;
        push_expected(nt);
        @(negedge clk);
        go = 1'b0;
        num_terms = 7'($urandom_range(127));
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!result_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output("valid_timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic wait_cnt(input int target, input int limit);
        int n = 0;
        while (32'(cnt_val) != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output("cnt_reach", 32'(cnt_val), 32'(target));
    endtask

    task automatic handshake(input int delay, input bit next_go, input int nt);
        repeat (delay) @(negedge clk);
        result_ready = 1'b1;
        if (next_go) begin
            go = 1'b1;
            num_terms = 7'(nt);
            push_expected(nt);
        end
        @(negedge clk);
        result_ready = 1'b0;
        go = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check_output(name, {30'd0, busy, result_valid}, 32'd0);
    endtask

    task automatic check_reset_values();
        check_output("rst_ctrl", {29'd0, start, reset_acc, busy}, 32'b100);
        check_output("rst_cnt", 32'(cnt_val), 32'd0);
        check_output("rst_result", {15'd0, result_valid, result}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on each rising result_valid and watches term sequencing.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_valid = 1'b0;
            exp_idx = 0;
        end else begin
            if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    check_output("result_value", 32'(result), 32'(popped.value));
                    check_output("valid_edge", 32'(edge_cnt), 32'(popped.edge_no));
                end
                held = result;
            end else if (result_valid) begin
                check_output("result_stable", 32'(result), 32'(held));
            end
            if (reset_acc) exp_idx = 0;
            if (!start) begin
                check_output("cnt_seq", 32'(cnt_val), 32'(exp_idx));
                exp_idx++;
            end
            if (!busy) check_output("idle_outputs", {23'd0, start, reset_acc, cnt_val}, 32'h100);
            prev_valid = result_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [DW-1:0] saved;
        int nt;
        int nt2;
        randomize_terms();
        #2 n_rst = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        // Ready while nothing is valid must be ignored.
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        result_ready = 1'b0;
        check_idle("ready_ignored");

        apply_stimulus(4);
        check_output("clear_state", {29'd0, reset_acc, start, busy}, 32'b111);
        wait_valid(20);
        handshake(0, 1'b0, 0);
        check_idle("s1_idle");

        apply_stimulus(0);
        wait_valid(100);
        handshake(0, 1'b0, 0);
        randomize_terms();
        apply_stimulus(100);
        wait_valid(100);
        handshake(0, 1'b0, 0);

        apply_stimulus(7);
        wait_valid(20);
        repeat (10) begin
            @(negedge clk);
            check_output("hold_valid", 32'(result_valid), 32'd1);
        end
        handshake(0, 1'b0, 0);
        check_idle("s3_idle");

        randomize_terms();
        apply_stimulus(5);
        wait_valid(20);
        handshake(1, 1'b1, 2);
        check_output("b2b_clear", {29'd0, reset_acc, busy, result_valid}, 32'b110);
        wait_valid(20);
        handshake(0, 1'b0, 0);

        saved = result;
        randomize_terms();
        apply_stimulus(64);
        wait_cnt(10, 40);
        abort = 1'b1;
        go = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go = 1'b0;
        void'(exp_q.pop_back());
        check_idle("abort_idle");
        check_output("abort_result", 32'(result), 32'(saved));
        repeat (80) @(negedge clk);

        apply_stimulus(30);
        wait_cnt(5, 40);
        #2 n_rst = 1'b0;
        #1 check_reset_values();
        void'(exp_q.pop_back());
        @(negedge clk);
        n_rst = 1'b1;
        randomize_terms();
        @(negedge clk);
        apply_stimulus(1);
        wait_valid(10);
        handshake(0, 1'b0, 0);

        for (int k = 0; k < 12; k++) begin
            randomize_terms();
            nt = ($urandom_range(1) == 0) ? int'($urandom_range(127)) : int'($urandom_range(10, 1));
            apply_stimulus(nt);
            wait_valid(150);
            if ($urandom_range(1) == 1) begin
                nt2 = int'($urandom_range(12));
                handshake(int'($urandom_range(3)), 1'b1, nt2);
                wait_valid(150);
            end
            handshake(int'($urandom_range(3)), 1'b0, 0);
            check_idle("rand_idle");
        end

        repeat (5) @(negedge clk);
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_sequencer.md
NODE_SEQUENCER -- requirements
Module: node_sequencer

Interface
REQ-001 SHALL take parameter MAX_TERMS, default 64, the maximum number of coef*data terms per node evaluation.
REQ-002 SHALL take parameter DATA_W, default 16, the width of the node result.
REQ-003 SHALL have port clk, input, 1, system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port go, input, 1, request to evaluate one node.
REQ-006 SHALL have port num_terms, input, 7, number of terms N to accumulate.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of the current evaluation.
REQ-008 SHALL have port node_out, input, DATA_W, activated node value returned by the node.
REQ-009 SHALL have port result_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port start, output, 1, node hold control: 1 = node accumulator holds, 0 = node adds term cnt_val this cycle.
REQ-011 SHALL have port reset_acc, output, 1, clears the node accumulator.
REQ-012 SHALL have port cnt_val, output, 7, index of the term the node consumes.
REQ-013 SHALL have port result, output, DATA_W, captured node value.
REQ-014 SHALL have port result_valid, output, 1, result is valid.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, ACCUM, SETTLE and RESULT, with every output registered.
REQ-017 In IDLE, start SHALL be 1, reset_acc 0 and cnt_val 0; a sampled go=1 SHALL move the block to CLEAR and latch the effective N.
REQ-018 Effective N SHALL equal num_terms when num_terms is in 1..MAX_TERMS; num_terms = 0 or greater than MAX_TERMS SHALL be treated as MAX_TERMS.
REQ-019 CLEAR SHALL last exactly 1 cycle with reset_acc=1, start=1 and cnt_val=0, then go to ACCUM.
REQ-020 ACCUM SHALL last exactly N cycles with start=0 and reset_acc=0, with cnt_val = 0, 1, ..., N-1 on consecutive cycles and no repeats or gaps; after the cycle with cnt_val = N-1 the block SHALL go to SETTLE.
REQ-021 SETTLE SHALL last 1 cycle with start=1 and cnt_val held at N-1; node_out SHALL be captured into result at the end of this cycle.
REQ-022 RESULT SHALL hold result_valid=1 and result stable until a cycle in which result_valid and result_ready are both 1.
REQ-023 On the RESULT handshake, go=1 in the same cycle SHALL move the block directly to CLEAR (back-to-back); otherwise it SHALL move to IDLE.
REQ-024 Latency: result_valid SHALL rise N+2 rising edges after the edge that sampled go.
REQ-025 go SHALL be ignored in CLEAR, ACCUM and SETTLE, and in RESULT unless the handshake occurs that cycle; num_terms changes SHALL not affect an evaluation in progress.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with result_valid=0 and result unchanged; abort SHALL take priority over go and over the handshake.
REQ-027 result_ready while result_valid=0 SHALL have no effect.
REQ-028 cnt_val SHALL never exceed MAX_TERMS-1.

Reset
REQ-029 n_rst=0 SHALL immediately force IDLE, start=1, reset_acc=0, cnt_val=0, result=0, result_valid=0 and busy=0, regardless of state (including mid-ACCUM).
REQ-030 After reset release, the first go SHALL produce a full CLEAR-ACCUM-SETTLE sequence.

Structure
REQ-031 MAX_TERMS, DATA_W, the cnt_val width (7) and the state enum SHALL live in the shared package nn_pkg.
REQ-032 The term counter (load/clear, increment, terminal-count flag at N-1) SHALL be a sub-module named term_counter; the FSM and result register SHALL be in node_sequencer.

Verification (bench uses a behavioural node model fed by start/reset_acc/cnt_val)
REQ-033 Scenario 1: num_terms=4, 1-cycle go pulse -> 1 CLEAR cycle, cnt_val 0,1,2,3 with start=0, 1 SETTLE cycle, result_valid rises at edge 6, result equals the model value.
REQ-034 Scenario 2: num_terms=0, then num_terms=100 -> each gives 64 ACCUM cycles with cnt_val 0..63 and result_valid at edge 66.
REQ-035 Scenario 3: result_ready held 0 for 10 cycles in RESULT -> result_valid and result stay stable; result_ready=1 -> IDLE next edge.
REQ-036 Scenario 4: go=1 during the RESULT handshake with num_terms=2 -> CLEAR on the next edge, no IDLE cycle, second result_valid 4 edges later.
REQ-037 Scenario 5: abort at cnt_val=10 of N=64 -> IDLE next edge, busy=0, result_valid never asserted, result unchanged.
REQ-038 Scenario 6: n_rst pulsed low mid-ACCUM -> outputs immediately take their reset values; the next go=1 with N=1 gives result_valid at edge 3.
